// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus receiver.
// Holds the interface-mode encoding, instruction constants, the two-line
// DDRAM wrap points and the address-step helper.
package lcd_pkg;

  typedef enum logic [1:0] {
    Mode8  = 2'd0,  // 8-bit interface, one edge per byte
    ModeHi = 2'd1,  // 4-bit interface, expecting upper nibble
    ModeLo = 2'd2   // 4-bit interface, expecting lower nibble
  } mode_e;

  localparam logic [7:0] InstrClear = 8'h01;
  localparam logic [7:0] InstrHome  = 8'h02;
  localparam logic [7:0] InstrEntry = 8'h04;
  localparam logic [7:0] InstrSetDd = 8'h80;
  localparam logic [3:0] NibFunc4   = 4'h2;

  localparam logic [6:0] AddrLine1End   = 7'h27;
  localparam logic [6:0] AddrLine2Start = 7'h40;
  localparam logic [6:0] AddrLine2End   = 7'h67;

  // Address counter step with two-line wrap; other addresses step by plain +/-1 mod 128.
  function automatic logic [6:0] next_addr(input logic [6:0] addr, input logic inc);
    logic [6:0] res;
    if (inc) begin
      if (addr == AddrLine1End)      res = AddrLine2Start;
      else if (addr == AddrLine2End) res = 7'h00;
      else                           res = addr + 7'd1;
    end else begin
      if (addr == AddrLine2Start)    res = AddrLine1End;
      else if (addr == 7'h00)        res = AddrLine2End;
      else                           res = addr - 7'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lcd_bus_rx_if.sv
// LCD pin bundle: enable strobe, register select, read/write and data nibble.
// master: the controller (or bench) driving the pins; slave: the receiver.
interface lcd_bus_rx_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_db;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_db);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_db);
endinterface

// File: rtl/lcd_in_sync.sv
// Input conditioning for the LCD pins.
// All pins share one synchronizer chain so they stay mutually aligned. An E high-time
// counter qualifies each falling edge.
//   strobe_o : accepted write edge (long enough, rw = 0), one cycle
//   short_o  : write edge rejected because E was high too briefly, one cycle
//   rs_o/db_o: pin values sampled in the last cycle E was high
module lcd_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned E_MIN_CYC   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [3:0] db_i,
  output logic       strobe_o,
  output logic       short_o,
  output logic       rs_o,
  output logic [3:0] db_o
);

  localparam int unsigned CntW = $clog2(E_MIN_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(E_MIN_CYC);

  // Bit layout: {e, rs, rw, db[3:0]}
  logic [6:0] sync_d [SYNC_STAGES];
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] last_d, last_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic s_e, fall, long_enough, last_rw;

  always_comb begin
    sync_d[0] = {e_i, rs_i, rw_i, db_i};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign s_e    = sync_q[SYNC_STAGES-1][6];
  assign last_d = sync_q[SYNC_STAGES-1];

  // Saturating high-time count; at the falling-edge cycle it holds the full high width.
  always_comb begin
    cnt_d = '0;
    if (s_e) cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fall        = last_q[6] & ~s_e;
  assign long_enough = (cnt_q >= CntMax);
  assign last_rw     = last_q[4];

  assign strobe_o = fall & long_enough & ~last_rw;
  assign short_o  = fall & ~long_enough & ~last_rw;
  assign rs_o     = last_q[5];
  assign db_o     = last_q[3:0];

endmodule

// File: rtl/lcd_bus_rx.sv
// HD44780-style 4-bit write-interface receiver / bus monitor.
// Reassembles nibbles into bytes and tracks interface mode, entry direction, DDRAM
// address and a busy-time model. It also flags short E pulses, split nibble pairs and
// writes made while busy.
// Ports: clk, rst (async, active-high); lcd (pin bundle, slave side);
//   byte_valid/byte_data/byte_rs/char_addr : emitted byte, one-cycle valid
//   ddram_addr, mode_4bit, busy             : tracked state
//   err_pulse, err_nibble, err_timing       : one-cycle error pulses
module lcd_bus_rx
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned E_MIN_CYC   = 12,
  parameter int unsigned BUSY_SHORT  = 2000,
  parameter int unsigned BUSY_LONG   = 82000
) (
  input  logic          clk,
  input  logic          rst,
  lcd_bus_rx_if.slave   lcd,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_rs,
  output logic [6:0]    char_addr,
  output logic [6:0]    ddram_addr,
  output logic          mode_4bit,
  output logic          busy,
  output logic          err_pulse,
  output logic          err_nibble,
  output logic          err_timing
);

  localparam int unsigned BusyW = $clog2(BUSY_LONG + 1);
  localparam logic [BusyW-1:0] BusyShort = BusyW'(BUSY_SHORT);
  localparam logic [BusyW-1:0] BusyLong  = BusyW'(BUSY_LONG);

  logic       strobe, short_e, in_rs;
  logic [3:0] in_db;

  lcd_in_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .E_MIN_CYC   (E_MIN_CYC)
  ) u_in_sync (
    .clk      (clk),
    .rst      (rst),
    .e_i      (lcd.lcd_e),
    .rs_i     (lcd.lcd_rs),
    .rw_i     (lcd.lcd_rw),
    .db_i     (lcd.lcd_db),
    .strobe_o (strobe),
    .short_o  (short_e),
    .rs_o     (in_rs),
    .db_o     (in_db)
  );

  mode_e            mode_d, mode_q;
  logic [3:0]       hi_d, hi_q;
  logic             hi_rs_d, hi_rs_q;
  logic             mode_4bit_d, mode_4bit_q;
  logic             id_d, id_q;
  logic [6:0]       ddram_d, ddram_q;
  logic [BusyW-1:0] busy_cnt_d, busy_cnt_q;
  logic             byte_valid_d, byte_valid_q;
  logic [7:0]       byte_data_d, byte_data_q;
  logic             byte_rs_d, byte_rs_q;
  logic [6:0]       char_addr_d, char_addr_q;
  logic             err_pulse_d, err_pulse_q;
  logic             err_nibble_d, err_nibble_q;
  logic             err_timing_d, err_timing_q;

  logic       emit;
  logic [7:0] emit_byte;
  logic       emit_rs;

  always_comb begin
    mode_d       = mode_q;
    hi_d         = hi_q;
    hi_rs_d      = hi_rs_q;
    mode_4bit_d  = mode_4bit_q;
    id_d         = id_q;
    ddram_d      = ddram_q;
    busy_cnt_d   = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_rs_d    = byte_rs_q;
    char_addr_d  = char_addr_q;
    err_pulse_d  = short_e;
    err_nibble_d = 1'b0;
    err_timing_d = 1'b0;
    emit         = 1'b0;
    emit_byte    = 8'h00;
    emit_rs      = 1'b0;

    if (strobe) begin
      unique case (mode_q)
        Mode8: begin
          emit      = 1'b1;
          emit_byte = {in_db, 4'h0};
          emit_rs   = in_rs;
          if (!in_rs && in_db == NibFunc4) begin
            mode_d      = ModeHi;
            mode_4bit_d = 1'b1;
          end
        end
        ModeHi: begin
          hi_d    = in_db;
          hi_rs_d = in_rs;
          mode_d  = ModeLo;
        end
        ModeLo: begin
          mode_d = ModeHi;
          if (in_rs == hi_rs_q) begin
            emit      = 1'b1;
            emit_byte = {hi_q, in_db};
            emit_rs   = in_rs;
          end else begin
            err_nibble_d = 1'b1;
          end
        end
        default: mode_d = Mode8;
      endcase
    end

    if (emit) begin
      byte_valid_d = 1'b1;
      byte_data_d  = emit_byte;
      byte_rs_d    = emit_rs;
      // The byte is decoded normally even when it arrives during busy.
      err_timing_d = (busy_cnt_q != '0);
      busy_cnt_d   = BusyShort;
      if (!emit_rs) begin
        if (emit_byte == InstrClear) begin
          ddram_d    = 7'h00;
          id_d       = 1'b1;
          busy_cnt_d = BusyLong;
        end else if (emit_byte[7:1] == InstrHome[7:1]) begin
          ddram_d    = 7'h00;
          busy_cnt_d = BusyLong;
        end else begin
          if (emit_byte[7:2] == InstrEntry[7:2]) id_d = emit_byte[1];
          if ((emit_byte & InstrSetDd) != 8'h00) ddram_d = emit_byte[6:0];
        end
      end else begin
        char_addr_d = ddram_q;
        ddram_d     = next_addr(ddram_q, id_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= Mode8;
      hi_q         <= 4'h0;
      hi_rs_q      <= 1'b0;
      mode_4bit_q  <= 1'b0;
      id_q         <= 1'b1;
      ddram_q      <= 7'h00;
      busy_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_rs_q    <= 1'b0;
      char_addr_q  <= 7'h00;
      err_pulse_q  <= 1'b0;
      err_nibble_q <= 1'b0;
      err_timing_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      hi_q         <= hi_d;
      hi_rs_q      <= hi_rs_d;
      mode_4bit_q  <= mode_4bit_d;
      id_q         <= id_d;
      ddram_q      <= ddram_d;
      busy_cnt_q   <= busy_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_rs_q    <= byte_rs_d;
      char_addr_q  <= char_addr_d;
      err_pulse_q  <= err_pulse_d;
      err_nibble_q <= err_nibble_d;
      err_timing_q <= err_timing_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_rs    = byte_rs_q;
  assign char_addr  = char_addr_q;
  assign ddram_addr = ddram_q;
  assign mode_4bit  = mode_4bit_q;
  assign busy       = (busy_cnt_q != '0);
  assign err_pulse  = err_pulse_q;
  assign err_nibble = err_nibble_q;
  assign err_timing = err_timing_q;

endmodule
